// File: rtl/bool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : bool_pkg                                                         |
// | Purpose : Shared types and constants for the truth-table sweep controller. |
// |           Holds the sweep FSM state encoding, default input count, default |
// |           truth-table width and settle counter width.                      |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package bool_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int DEF_N_VARS = 3;
  localparam int TT_W       = 1 << DEF_N_VARS;
  localparam int CNT_W      = 4;

endpackage
`default_nettype wire

// File: rtl/bool_tt_compare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bool_tt_compare                                                  |
// | Purpose : Purely combinational comparison of a captured truth table       |
// |           against the expected table.                                      |
// | Ports   : tt, expected        - captured and expected tables (2^N_VARS b)  |
// |           match               - tables identical                           |
// |           err_count           - number of differing bits                   |
// |           first_err           - lowest differing index                     |
// |           first_err_valid     - at least one bit differs                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bool_tt_compare
  import bool_pkg::*;
#(
  parameter int N_VARS = DEF_N_VARS
) (
  input  logic [(1<<N_VARS)-1:0] tt,
  input  logic [(1<<N_VARS)-1:0] expected,
  output logic                   match,
  output logic [N_VARS:0]        err_count,
  output logic [N_VARS-1:0]      first_err,
  output logic                   first_err_valid
);

  localparam int TT_BITS = 1 << N_VARS;

  logic [TT_BITS-1:0] w_diff;

  assign w_diff = tt ^ expected;

  // Scanning from the top down lets the last hit win, which is the lowest
  // failing index.
  always_comb begin
    match           = (w_diff == '0);
    err_count       = '0;
    first_err       = '0;
    first_err_valid = 1'b0;
    for (int i = TT_BITS - 1; i >= 0; i--) begin
      err_count = err_count + {{N_VARS{1'b0}}, w_diff[i]};
      if (w_diff[i]) begin
        first_err       = N_VARS'(i);
        first_err_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bool_tt_sweeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bool_tt_sweeper                                                  |
// | Purpose : Steps a single-output Boolean function through all input        |
// |           combinations, captures its truth table and compares it with an  |
// |           expected minterm mask.                                          |
// | Ports   : clk, rst_n          - clock, async active-low reset              |
// |           start, abort        - begin / cancel a sweep                     |
// |           expected            - expected table, latched on start           |
// |           abc, f              - function inputs / function output          |
// |           busy, done          - sweep running / one-cycle completion pulse |
// |           tt                  - captured truth table                       |
// |           match, err_count,   - comparison results, registered at the end  |
// |           first_err(_valid)     of a sweep and held until the next start   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bool_tt_sweeper
  import bool_pkg::*;
#(
  parameter int N_VARS = DEF_N_VARS,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_VARS)-1:0] expected,
  output logic [N_VARS-1:0]      abc,
  input  logic                   f,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_VARS)-1:0] tt,
  output logic                   match,
  output logic [N_VARS:0]        err_count,
  output logic [N_VARS-1:0]      first_err,
  output logic                   first_err_valid
);

  localparam int TT_BITS = 1 << N_VARS;

  state_e               state_q, state_d;
  logic [N_VARS-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TT_BITS-1:0]   tt_q, tt_d;
  logic [TT_BITS-1:0]   exp_q, exp_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 match_q, match_d;
  logic [N_VARS:0]      err_count_q, err_count_d;
  logic [N_VARS-1:0]    first_err_q, first_err_d;
  logic                 first_err_valid_q, first_err_valid_d;

  // Table as it will look after the current vector is captured. Comparing on
  // this lets the results be registered on the same edge that enters FINISH.
  logic [TT_BITS-1:0]   w_tt_smp;
  logic                 w_cmp_match;
  logic [N_VARS:0]      w_cmp_err_count;
  logic [N_VARS-1:0]    w_cmp_first_err;
  logic                 w_cmp_first_err_valid;

  always_comb begin
    w_tt_smp        = tt_q;
    w_tt_smp[idx_q] = f;
  end

  bool_tt_compare #(
    .N_VARS(N_VARS)
  ) u_compare (
    .tt              (w_tt_smp),
    .expected        (exp_q),
    .match           (w_cmp_match),
    .err_count       (w_cmp_err_count),
    .first_err       (w_cmp_first_err),
    .first_err_valid (w_cmp_first_err_valid)
  );

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    cnt_d             = cnt_q;
    tt_d              = tt_q;
    exp_d             = exp_q;
    match_d           = match_q;
    err_count_d       = err_count_q;
    first_err_d       = first_err_q;
    first_err_valid_d = first_err_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d             = '0;
          cnt_d             = '0;
          tt_d              = '0;
          exp_d             = expected;
          match_d           = 1'b0;
          err_count_d       = '0;
          first_err_d       = '0;
          first_err_valid_d = 1'b0;
          state_d           = (SETTLE == 0) ? SAMPLE : APPLY;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        tt_d  = w_tt_smp;
        cnt_d = '0;
        idx_d = idx_q + N_VARS'(1);
        if (&idx_q) begin
          state_d           = FINISH;
          match_d           = w_cmp_match;
          err_count_d       = w_cmp_err_count;
          first_err_d       = w_cmp_first_err;
          first_err_valid_d = w_cmp_first_err_valid;
        end else begin
          state_d = (SETTLE == 0) ? SAMPLE : APPLY;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything while a sweep runs, including the final
    // sample, so an aborted sweep never reaches FINISH.
    if (abort && (state_q == APPLY || state_q == SAMPLE)) begin
      state_d           = IDLE;
      idx_d             = '0;
      cnt_d             = '0;
      tt_d              = '0;
      match_d           = 1'b0;
      err_count_d       = '0;
      first_err_d       = '0;
      first_err_valid_d = 1'b0;
    end

    busy_d = (state_d == APPLY) || (state_d == SAMPLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      cnt_q             <= '0;
      tt_q              <= '0;
      exp_q             <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      match_q           <= 1'b0;
      err_count_q       <= '0;
      first_err_q       <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      cnt_q             <= cnt_d;
      tt_q              <= tt_d;
      exp_q             <= exp_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      match_q           <= match_d;
      err_count_q       <= err_count_d;
      first_err_q       <= first_err_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign abc             = idx_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign tt              = tt_q;
  assign match           = match_q;
  assign err_count       = err_count_q;
  assign first_err       = first_err_q;
  assign first_err_valid = first_err_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bool_tt_sweeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bool_tt_sweeper                                               |
// | Purpose : Self-checking bench for bool_tt_sweeper. Three instances with    |
// |           SETTLE = 1, 2 and 0 drive a POS function, either directly or     |
// |           through one flop; expected results are queued when a sweep is   |
// |           launched and compared when done pulses.                          |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_bool_tt_sweeper;

  typedef struct {
    logic [7:0] tt;
    logic       m;
    logic [3:0] ec;
    logic [2:0] fe;
    logic       fev;
    int         lat;
  } exp_t;

  exp_t sbq[$];

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_s;
  logic [2:0] abort_s;
  logic [7:0] exp_s [3];
  logic [2:0] abc_s [3];
  logic [2:0] busy_s;
  logic [2:0] done_s;
  logic [7:0] tt_s [3];
  logic [2:0] match_s;
  logic [3:0] ec_s [3];
  logic [2:0] fe_s [3];
  logic [2:0] fev_s;
  logic       f1_tied;
  logic       f0;
  logic       f1;
  logic       f2;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  function automatic logic fmod(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return (a | b | c) & (a | ~b | c) & (~a | b | ~c) & (~a | ~b | ~c);
  endfunction

  assign f1 = f1_tied ? 1'b1 : fmod(abc_s[1]);

  initial begin
    f0 = 1'b0;
    f2 = 1'b0;
  end
  always @(posedge clk) begin
    f0 <= fmod(abc_s[0]);
    f2 <= fmod(abc_s[2]);
  end

  bool_tt_sweeper #(.N_VARS(3), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .expected(exp_s[0]), .abc(abc_s[0]), .f(f0), .busy(busy_s[0]),
    .done(done_s[0]), .tt(tt_s[0]), .match(match_s[0]), .err_count(ec_s[0]),
    .first_err(fe_s[0]), .first_err_valid(fev_s[0]));

  bool_tt_sweeper #(.N_VARS(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .expected(exp_s[1]), .abc(abc_s[1]), .f(f1), .busy(busy_s[1]),
    .done(done_s[1]), .tt(tt_s[1]), .match(match_s[1]), .err_count(ec_s[1]),
    .first_err(fe_s[1]), .first_err_valid(fev_s[1]));

  bool_tt_sweeper #(.N_VARS(3), .SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
    .expected(exp_s[2]), .abc(abc_s[2]), .f(f2), .busy(busy_s[2]),
    .done(done_s[2]), .tt(tt_s[2]), .match(match_s[2]), .err_count(ec_s[2]),
    .first_err(fe_s[2]), .first_err_valid(fev_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_result(input logic [7:0] exp_tt, input logic [7:0] expv, input int settle);
    exp_t       e;
    logic [7:0] diff;
    diff  = exp_tt ^ expv;
    e.tt  = exp_tt;
    e.m   = (diff == 8'h00);
    e.ec  = 4'd0;
    e.fe  = 3'd0;
    e.fev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (diff[i]) begin
        e.ec = e.ec + 4'd1;
        if (!e.fev) begin
          e.fe  = 3'(i);
          e.fev = 1'b1;
        end
      end
    end
    e.lat = 8 * (settle + 1);
    sbq.push_back(e);
  endtask

  task automatic start_pulse(input int d, input logic [7:0] expv, input logic ab);
    @(negedge clk);
    exp_s[d]   = expv;
    start_s[d] = 1'b1;
    abort_s[d] = ab;
    @(negedge clk);
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
  endtask

  task automatic finish_sweep(input int d, input int offset, input string tag);
    int   n;
    int   nb;
    exp_t e;
    n  = 0;
    nb = 0;
    while (!done_s[d] && n < 400) begin
      if (busy_s[d]) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done_s[d], 1);
    chk({tag, "_busy_at_done"}, busy_s[d], 0);
    chk({tag, "_sb_nonempty"}, sbq.size() != 0, 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_tt"}, tt_s[d], e.tt);
      chk({tag, "_match"}, match_s[d], e.m);
      chk({tag, "_err_count"}, ec_s[d], e.ec);
      chk({tag, "_first_err"}, fe_s[d], e.fe);
      chk({tag, "_first_err_valid"}, fev_s[d], e.fev);
      chk({tag, "_latency"}, n + offset, e.lat);
      chk({tag, "_busy_cycles"}, nb + offset, e.lat);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done_s[d], 0);
      chk({tag, "_tt_held"}, tt_s[d], e.tt);
      chk({tag, "_match_held"}, match_s[d], e.m);
    end
  endtask

  task automatic expect_no_done(input int d, input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_s[d]) seen++;
    end
    chk({tag, "_no_done"}, seen, 0);
  endtask

  initial begin
    logic [7:0] tt_reg0;
    logic [7:0] tt_f;
    start_s = 3'b000;
    abort_s = 3'b000;
    f1_tied = 1'b0;
    for (int d = 0; d < 3; d++) exp_s[d] = 8'h00;

    // F truth table built straight from the POS expression
    for (int i = 0; i < 8; i++) tt_f[i] = fmod(3'(i));
    // One-flop function with no settle time lags by one vector
    tt_reg0 = 8'h00;
    for (int i = 1; i < 8; i++) tt_reg0[i] = fmod(3'(i - 1));

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", busy_s[d], 0);
      chk("rst_done", done_s[d], 0);
      chk("rst_tt", tt_s[d], 0);
      chk("rst_abc", abc_s[d], 0);
      chk("rst_match", match_s[d], 0);
      chk("rst_err_count", ec_s[d], 0);
      chk("rst_first_err_valid", fev_s[d], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("model_tt_f", tt_f, 8'h5A);

    // Matching sweep; abort given together with start is ignored in IDLE
    expect_result(8'h5A, 8'h5A, 1);
    start_pulse(1, 8'h5A, 1'b1);
    chk("t1_abc_first", abc_s[1], 0);
    finish_sweep(1, 0, "t1");

    // Single mismatch at index 0
    expect_result(8'h5A, 8'h5B, 1);
    start_pulse(1, 8'h5B, 1'b0);
    finish_sweep(1, 0, "t2");

    // Function tied high against an all-zero mask
    f1_tied = 1'b1;
    expect_result(8'hFF, 8'h00, 1);
    start_pulse(1, 8'h00, 1'b0);
    finish_sweep(1, 0, "t3");
    f1_tied = 1'b0;

    // Abort sampled at edge k+6
    start_pulse(1, 8'h5A, 1'b0);
    chk("t4_results_cleared", ec_s[1], 0);
    repeat (5) @(negedge clk);
    chk("t4_busy_before", busy_s[1], 1);
    chk("t4_tt_partial", tt_s[1], 8'h02);
    abort_s[1] = 1'b1;
    @(negedge clk);
    abort_s[1] = 1'b0;
    chk("t4_busy_after", busy_s[1], 0);
    chk("t4_tt_cleared", tt_s[1], 0);
    chk("t4_abc_cleared", abc_s[1], 0);
    chk("t4_done_after", done_s[1], 0);
    expect_no_done(1, 30, "t4");

    // Normal sweep after abort
    expect_result(8'h5A, 8'h5A, 1);
    start_pulse(1, 8'h5A, 1'b0);
    finish_sweep(1, 0, "t5");

    // Start re-asserted at k+5 with a different mask must be ignored
    expect_result(8'h5A, 8'h5A, 1);
    start_pulse(1, 8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    exp_s[1]   = 8'h00;
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    finish_sweep(1, 5, "t6");

    // Asynchronous reset during cycle k+9
    start_pulse(1, 8'h5A, 1'b0);
    repeat (8) @(negedge clk);
    chk("t7_busy_before", busy_s[1], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_busy", busy_s[1], 0);
    chk("t7_tt", tt_s[1], 0);
    chk("t7_abc", abc_s[1], 0);
    chk("t7_done", done_s[1], 0);
    chk("t7_match", match_s[1], 0);
    chk("t7_err_count", ec_s[1], 0);
    chk("t7_first_err", fe_s[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done(1, 30, "t7");

    // Registered function, SETTLE=2
    expect_result(tt_f, 8'h5A, 2);
    start_pulse(2, 8'h5A, 1'b0);
    finish_sweep(2, 0, "t8");

    // Registered function, SETTLE=0: captures the previous vector's output
    expect_result(tt_reg0, 8'h5A, 0);
    start_pulse(0, 8'h5A, 1'b0);
    finish_sweep(0, 0, "t9");
    chk("t9_mismatch", match_s[0], 0);

    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
